port_uart_tx: RTL

PORT_UART_TX -- requirements
Module: port_uart_tx

---
 rtl/port_uart_tx.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/port_uart_tx.sv
// 8N1 UART transmitter fed by a small write FIFO; frames leave back-to-back while bytes are queued.
// A dropped write (FIFO full) sets a sticky overflow flag until cleared.
module port_uart_tx #(
   parameter int unsigned CLKS_PER_BIT = 868,
   parameter int unsigned FIFO_DEPTH = 4,
   localparam int unsigned MEMORY_DATA_BITS = 8,
   localparam int unsigned COUNT_W = $clog2(FIFO_DEPTH + 1)
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        wr_en,
   input  logic [MEMORY_DATA_BITS-1:0] wr_data,
   input  logic                        ovf_clr,
   output logic                        tx,
   output logic                        busy,
   output logic [COUNT_W-1:0]          fifo_count,
   output logic                        fifo_full,
   output logic                        overflow
);

   localparam int unsigned PTR_W     = $clog2(FIFO_DEPTH);
   localparam int unsigned BIT_CNT_W = $clog2(CLKS_PER_BIT);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t                      state, state_n;
   logic [BIT_CNT_W-1:0]        bit_cnt, bit_cnt_n;
   logic [2:0]                  bit_idx, bit_idx_n;
   logic [MEMORY_DATA_BITS-1:0] shreg, shreg_n;
   logic                        tx_n;
   logic [PTR_W-1:0]            wr_ptr, wr_ptr_n, rd_ptr, rd_ptr_n;
   logic [COUNT_W-1:0]          count_n;
   logic                        full_n, ovf_n;
   logic                        push_c, pop_c, bit_end_c;

   logic [MEMORY_DATA_BITS-1:0] mem [FIFO_DEPTH];

   assign bit_end_c = (bit_cnt == BIT_CNT_W'(CLKS_PER_BIT - 1));
   assign push_c    = wr_en && !fifo_full;

   // Next-state, shifter, FIFO bookkeeping and overflow flag
   always_comb begin
      state_n   = state;
      bit_cnt_n = bit_cnt;
      bit_idx_n = bit_idx;
      shreg_n   = shreg;
      tx_n      = tx;
      pop_c     = 1'b0;

      case (state)
         IDLE: begin
            tx_n      = 1'b1;
            bit_cnt_n = '0;
            if (fifo_count != '0) begin
               pop_c   = 1'b1;
               shreg_n = mem[rd_ptr];
               state_n = START;
               tx_n    = 1'b0;
            end
         end
         START: begin
            if (bit_end_c) begin
               bit_cnt_n = '0;
               bit_idx_n = '0;
               state_n   = DATA;
               tx_n      = shreg[0];
            end else begin
               bit_cnt_n = bit_cnt + BIT_CNT_W'(1);
            end
         end
         DATA: begin
            if (bit_end_c) begin
               bit_cnt_n = '0;
               if (bit_idx == 3'd7) begin
                  state_n = STOP;
                  tx_n    = 1'b1;
               end else begin
                  bit_idx_n = bit_idx + 3'd1;
                  shreg_n   = {1'b0, shreg[MEMORY_DATA_BITS-1:1]};
                  tx_n      = shreg[1];
               end
            end else begin
               bit_cnt_n = bit_cnt + BIT_CNT_W'(1);
            end
         end
         STOP: begin
            if (bit_end_c) begin
               bit_cnt_n = '0;
               if (fifo_count != '0) begin
                  pop_c   = 1'b1;
                  shreg_n = mem[rd_ptr];
                  state_n = START;
                  tx_n    = 1'b0;
               end else begin
                  state_n = IDLE;
                  tx_n    = 1'b1;
               end
            end else begin
               bit_cnt_n = bit_cnt + BIT_CNT_W'(1);
            end
         end
         default: begin
            state_n = IDLE;
            tx_n    = 1'b1;
         end
      endcase

      wr_ptr_n = push_c ? wr_ptr + PTR_W'(1) : wr_ptr;
      rd_ptr_n = pop_c  ? rd_ptr + PTR_W'(1) : rd_ptr;
      count_n  = fifo_count + COUNT_W'(push_c) - COUNT_W'(pop_c);
      full_n   = (count_n == COUNT_W'(FIFO_DEPTH));

      // A dropped write outranks a clear in the same cycle
      ovf_n = overflow;
      if (ovf_clr)
         ovf_n = 1'b0;
      if (wr_en && fifo_full)
         ovf_n = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         bit_cnt    <= '0;
         bit_idx    <= '0;
         shreg      <= '0;
         tx         <= 1'b1;
         busy       <= 1'b0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
         fifo_full  <= 1'b0;
         overflow   <= 1'b0;
      end else begin
         state      <= state_n;
         bit_cnt    <= bit_cnt_n;
         bit_idx    <= bit_idx_n;
         shreg      <= shreg_n;
         tx         <= tx_n;
         busy       <= (state_n != IDLE);
         wr_ptr     <= wr_ptr_n;
         rd_ptr     <= rd_ptr_n;
         fifo_count <= count_n;
         fifo_full  <= full_n;
         overflow   <= ovf_n;
      end
   end

   // Storage needs no reset; pointers and count define validity
   always_ff @(posedge clk) begin
      if (push_c && !reset)
         mem[wr_ptr] <= wr_data;
   end

endmodule
